// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle for decode_queue.
// The DUT takes the slave modport; fetch/issue logic (or a bench) takes master.
interface decode_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_instr;
    logic [23:0]     out_ctrl;
    logic            out_invalid;
    logic [CntW-1:0] out_count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_ctrl, out_invalid, out_count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_ctrl, out_invalid, out_count
    );
endinterface

// File: rtl/decode_queue.sv
// Decoding instruction FIFO between fetch and issue: decodes on entry, stores the control
// bundle alongside {pc, instr}, presents the head entry masked to zero while empty.
module decode_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter bit          ENABLE_ERET = 1'b1
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    decode_queue_if.slave q
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    // Bit positions inside the 23 stored control bits; out_ctrl[23] is spare and reads 0.
    localparam int unsigned BRegWrite = 22;
    localparam int unsigned BRegDst   = 21;
    localparam int unsigned BAluSrc   = 20;
    localparam int unsigned BBranch   = 19;
    localparam int unsigned BMemEn    = 18;
    localparam int unsigned BMemToReg = 17;
    localparam int unsigned BJump     = 16;
    localparam int unsigned BJal      = 15;
    localparam int unsigned BJr       = 14;
    localparam int unsigned BJalr     = 13;
    localparam int unsigned BBal      = 12;
    localparam int unsigned BAluHiLo  = 7;
    localparam int unsigned BMtc0     = 4;
    localparam int unsigned BMfc0     = 3;
    localparam int unsigned BBrk      = 2;
    localparam int unsigned BCall     = 1;
    localparam int unsigned BEret     = 0;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    logic [22:0] dec_ctrl;
    logic        dec_invalid;

    assign op    = q.in_instr[31:26];
    assign rs    = q.in_instr[25:21];
    assign rt    = q.in_instr[20:16];
    assign funct = q.in_instr[5:0];

    always_comb begin
        dec_ctrl    = '0;
        dec_invalid = 1'b0;
        if (q.in_instr != 32'h0) begin
            case (op)
                6'b111111: begin
                    dec_ctrl[BRegWrite] = 1'b1;
                    dec_ctrl[BRegDst]   = 1'b1;
                end
                6'b001000, 6'b001001, 6'b001010, 6'b001011,
                6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                    dec_ctrl[BRegWrite] = 1'b1;
                    dec_ctrl[BAluSrc]   = 1'b1;
                end
                6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_ctrl[BBranch] = 1'b1;
                6'b000010: dec_ctrl[BJump] = 1'b1;
                6'b000011: begin
                    dec_ctrl[BRegWrite] = 1'b1;
                    dec_ctrl[BJal]      = 1'b1;
                end
                6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                    dec_ctrl[BRegWrite] = 1'b1;
                    dec_ctrl[BAluSrc]   = 1'b1;
                    dec_ctrl[BMemEn]    = 1'b1;
                    dec_ctrl[BMemToReg] = 1'b1;
                end
                6'b101000, 6'b101001, 6'b101011: begin
                    dec_ctrl[BAluSrc] = 1'b1;
                    dec_ctrl[BMemEn]  = 1'b1;
                    dec_ctrl[11:8]    = (op == 6'b101000) ? 4'b0001 :
                                        (op == 6'b101001) ? 4'b0011 : 4'b1111;
                end
                6'b000000: begin
                    case (funct)
                        6'b010000, 6'b010010: begin
                            dec_ctrl[BRegWrite] = 1'b1;
                            dec_ctrl[BRegDst]   = 1'b1;
                            dec_ctrl[BAluHiLo]  = 1'b1;
                        end
                        6'b010001: dec_ctrl[6:5] = 2'b10;
                        6'b010011: dec_ctrl[6:5] = 2'b01;
                        6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_ctrl[6:5] = 2'b11;
                        6'b001000: begin
                            dec_ctrl[BJump] = 1'b1;
                            dec_ctrl[BJr]   = 1'b1;
                        end
                        6'b001001: begin
                            dec_ctrl[BRegWrite] = 1'b1;
                            dec_ctrl[BRegDst]   = 1'b1;
                            dec_ctrl[BJalr]     = 1'b1;
                        end
                        6'b001101: dec_ctrl[BBrk]  = 1'b1;
                        6'b001100: dec_ctrl[BCall] = 1'b1;
                        6'b100100, 6'b100101, 6'b100110, 6'b100111,
                        6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b101010, 6'b101011: begin
                            dec_ctrl[BRegWrite] = 1'b1;
                            dec_ctrl[BRegDst]   = 1'b1;
                        end
                        default: dec_invalid = 1'b1;
                    endcase
                end
                6'b000001: begin
                    case (rt)
                        5'b00000, 5'b00001: dec_ctrl[BBranch] = 1'b1;
                        5'b10000, 5'b10001: begin
                            dec_ctrl[BRegWrite] = 1'b1;
                            dec_ctrl[BBranch]   = 1'b1;
                            dec_ctrl[BBal]      = 1'b1;
                        end
                        default: dec_invalid = 1'b1;
                    endcase
                end
                6'b010000: begin
                    if (rs == 5'b00100) begin
                        dec_ctrl[BRegDst] = 1'b1;
                        dec_ctrl[BMtc0]   = 1'b1;
                    end else if (rs == 5'b00000) begin
                        dec_ctrl[BRegWrite] = 1'b1;
                        dec_ctrl[BMfc0]     = 1'b1;
                    end else if (ENABLE_ERET && rs == 5'b10000 && funct == 6'b011000) begin
                        dec_ctrl[BEret] = 1'b1;
                    end else begin
                        dec_invalid = 1'b1;
                    end
                end
                default: dec_invalid = 1'b1;
            endcase
        end
    end

    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, push, pop;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [22:0] ctrl_mem  [DEPTH];
    logic        inv_mem   [DEPTH];

    // Full/empty come only from registered occupancy, so out_ready never reaches in_ready.
    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    assign push  = q.in_valid && !full;
    assign pop   = !empty && q.out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wptr_q]    <= q.in_pc;
            instr_mem[wptr_q] <= q.in_instr;
            ctrl_mem[wptr_q]  <= dec_ctrl;
            inv_mem[wptr_q]   <= dec_invalid;
        end
    end

    assign q.in_ready    = !full;
    assign q.out_valid   = !empty;
    assign q.out_count   = count_q;
    assign q.out_pc      = empty ? 32'h0 : pc_mem[rptr_q];
    assign q.out_instr   = empty ? 32'h0 : instr_mem[rptr_q];
    assign q.out_ctrl    = empty ? 24'h0 : {1'b0, ctrl_mem[rptr_q]};
    assign q.out_invalid = empty ? 1'b0 : inv_mem[rptr_q];
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: FIFO ordering, backpressure, wrap, decode table, flush, reset.
module tb_decode_queue;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp  = 0;
    int   n_fail = 0;

    decode_queue_if #(.DEPTH(4)) qa ();
    decode_queue_if #(.DEPTH(4)) qb ();

    decode_queue #(.DEPTH(4), .ENABLE_ERET(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .q(qa)
    );
    decode_queue #(.DEPTH(4), .ENABLE_ERET(1'b0)) dut_ne (
        .clk(clk), .rst(rst), .flush(flush), .q(qb)
    );

    always #5 clk = ~clk;

    // Expected control words, bit 22 = regwrite down to bit 0 = eret.
    localparam logic [23:0] CLw     = 24'h560000;
    localparam logic [23:0] CSw     = 24'h140F00;
    localparam logic [23:0] CCall   = 24'h000002;
    localparam logic [23:0] CRegRd  = 24'h600000;
    localparam logic [23:0] CJal    = 24'h408000;
    localparam logic [23:0] CBal    = 24'h481000;
    localparam logic [23:0] CMthi   = 24'h000040;
    localparam logic [23:0] COri    = 24'h500000;
    localparam logic [23:0] CEret   = 24'h000001;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] instr);
        qa.in_valid = 1'b1;
        qa.in_pc    = pc;
        qa.in_instr = instr;
        tick();
        qa.in_valid = 1'b0;
    endtask

    logic [31:0] v_pc   [4];
    logic [31:0] v_ins  [4];
    logic [23:0] v_ctrl [4];
    logic        v_inv  [4];

    initial begin
        rst = 1'b1; flush = 1'b0;
        qa.in_valid = 1'b0; qa.in_pc = '0; qa.in_instr = '0; qa.out_ready = 1'b0;
        qb.in_valid = 1'b0; qb.in_pc = '0; qb.in_instr = '0; qb.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(qa.out_valid), 64'd0);
        check("rst_in_ready", 64'(qa.in_ready), 64'd1);
        check("rst_count", 64'(qa.out_count), 64'd0);
        check("rst_out_pc", 64'(qa.out_pc), 64'd0);
        check("rst_out_ctrl", 64'(qa.out_ctrl), 64'd0);

        // Single LW, zero extra latency
        push1(32'hBFC00000, 32'h8C430004);
        check("lw_valid", 64'(qa.out_valid), 64'd1);
        check("lw_ctrl", 64'(qa.out_ctrl), 64'(CLw));
        check("lw_count", 64'(qa.out_count), 64'd1);
        check("lw_pc", 64'(qa.out_pc), 64'hBFC00000);
        check("lw_instr", 64'(qa.out_instr), 64'h8C430004);
        check("lw_inv", 64'(qa.out_invalid), 64'd0);
        qa.out_ready = 1'b1; tick(); qa.out_ready = 1'b0;
        check("lw_pop_count", 64'(qa.out_count), 64'd0);

        // Fill to full with out_ready=0
        v_pc[0] = 32'h1000; v_ins[0] = 32'h00221821; v_ctrl[0] = CRegRd; // ADDU
        v_pc[1] = 32'h1004; v_ins[1] = 32'h0C000010; v_ctrl[1] = CJal;   // JAL
        v_pc[2] = 32'h1008; v_ins[2] = 32'h04100003; v_ctrl[2] = CBal;   // BLTZAL
        v_pc[3] = 32'h100C; v_ins[3] = 32'h00400011; v_ctrl[3] = CMthi;  // MTHI
        for (int i = 0; i < 4; i++) push1(v_pc[i], v_ins[i]);
        check("full_in_ready", 64'(qa.in_ready), 64'd0);
        check("full_count", 64'(qa.out_count), 64'd4);
        check("full_stable_pc", 64'(qa.out_pc), 64'h1000);
        // Pop while full must not let a push in the same cycle
        qa.in_valid = 1'b1; qa.in_pc = 32'hDEAD; qa.in_instr = 32'h0; qa.out_ready = 1'b1;
        #1;
        check("full_pop_in_ready", 64'(qa.in_ready), 64'd0);
        tick();
        qa.in_valid = 1'b0;
        check("full_pop_count", 64'(qa.out_count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            check("fifo_pc", 64'(qa.out_pc), 64'(v_pc[i]));
            check("fifo_instr", 64'(qa.out_instr), 64'(v_ins[i]));
            check("fifo_ctrl", 64'(qa.out_ctrl), 64'(v_ctrl[i]));
            tick();
        end
        qa.out_ready = 1'b0;
        check("drain_valid", 64'(qa.out_valid), 64'd0);
        check("drain_in_ready", 64'(qa.in_ready), 64'd1);

        // Simultaneous push/pop at count 2 across pointer wrap
        push1(32'h2000, 32'h34000000);
        push1(32'h2004, 32'h34000001);
        for (int c = 0; c < 10; c++) begin
            qa.in_valid = 1'b1; qa.out_ready = 1'b1;
            qa.in_pc = 32'h2000 + 32'(4 * (c + 2));
            qa.in_instr = 32'h34000000 + 32'(c + 2);
            check("pp_head_pc", 64'(qa.out_pc), 64'(32'h2000 + 32'(4 * c)));
            tick();
            check("pp_count", 64'(qa.out_count), 64'd2);
        end
        qa.in_valid = 1'b0; qa.out_ready = 1'b0;
        check("pp_final_pc", 64'(qa.out_pc), 64'h2028);
        check("pp_final_instr", 64'(qa.out_instr), 64'h3400000A);
        check("pp_final_ctrl", 64'(qa.out_ctrl), 64'(COri));
        qa.out_ready = 1'b1; tick(); tick(); qa.out_ready = 1'b0;
        check("pp_drain_count", 64'(qa.out_count), 64'd0);

        // Decode table corners
        v_ins[0] = 32'hAC000000; v_ctrl[0] = CSw;    v_inv[0] = 1'b0;
        v_ins[1] = 32'h0000000C; v_ctrl[1] = CCall;  v_inv[1] = 1'b0;
        v_ins[2] = 32'hFC000000; v_ctrl[2] = CRegRd; v_inv[2] = 1'b0;
        v_ins[3] = 32'h7C000001; v_ctrl[3] = 24'h0;  v_inv[3] = 1'b1;
        for (int i = 0; i < 4; i++) push1(32'h5000 + 32'(4 * i), v_ins[i]);
        qa.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("dec_ctrl", 64'(qa.out_ctrl), 64'(v_ctrl[i]));
            check("dec_invalid", 64'(qa.out_invalid), 64'(v_inv[i]));
            tick();
        end
        qa.out_ready = 1'b0;

        // ERET with and without support, plus NOP
        push1(32'h6000, 32'h42000018);
        check("eret_ctrl", 64'(qa.out_ctrl), 64'(CEret));
        check("eret_inv", 64'(qa.out_invalid), 64'd0);
        qa.out_ready = 1'b1; tick(); qa.out_ready = 1'b0;
        push1(32'h6004, 32'h00000000);
        check("nop_ctrl", 64'(qa.out_ctrl), 64'd0);
        check("nop_inv", 64'(qa.out_invalid), 64'd0);
        check("nop_valid", 64'(qa.out_valid), 64'd1);
        qa.out_ready = 1'b1; tick(); qa.out_ready = 1'b0;
        qb.in_valid = 1'b1; qb.in_pc = 32'h6000; qb.in_instr = 32'h42000018;
        tick();
        qb.in_valid = 1'b0;
        check("noeret_inv", 64'(qb.out_invalid), 64'd1);
        check("noeret_ctrl", 64'(qb.out_ctrl), 64'd0);
        check("noeret_valid", 64'(qb.out_valid), 64'd1);

        // Flush at count 3 drops the offered entry too
        for (int i = 0; i < 3; i++) push1(32'h3000 + 32'(4 * i), 32'h34000000);
        check("preflush_count", 64'(qa.out_count), 64'd3);
        flush = 1'b1; qa.in_valid = 1'b1; qa.in_pc = 32'h3FFC; qa.in_instr = 32'h8C430004;
        tick();
        flush = 1'b0; qa.in_valid = 1'b0;
        check("flush_count", 64'(qa.out_count), 64'd0);
        check("flush_valid", 64'(qa.out_valid), 64'd0);
        check("flush_in_ready", 64'(qa.in_ready), 64'd1);
        push1(32'h4000, 32'h8C430004);
        check("postflush_pc", 64'(qa.out_pc), 64'h4000);
        check("postflush_count", 64'(qa.out_count), 64'd1);
        push1(32'h4004, 32'h34000000);

        // Asynchronous reset mid-cycle
        rst = 1'b1;
        #1;
        check("arst_count", 64'(qa.out_count), 64'd0);
        check("arst_valid", 64'(qa.out_valid), 64'd0);
        check("arst_pc", 64'(qa.out_pc), 64'd0);
        check("arst_ne_valid", 64'(qb.out_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_in_ready", 64'(qa.in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
